// File: rtl/vga_mem_pkg.sv
// Shared types and default widths for the frame/board RAM port-b arbiter.
package vga_mem_pkg;

  localparam int MEM_ADDR_W = 17;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_HOST = 2'd2
  } rd_tag_t;

  typedef enum logic {
    ST_NORMAL     = 1'b0,
    ST_FORCE_HOST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/vga_mem_arbiter_if.sv
// Display and host read channels plus the RAM port-b side of the arbiter.
interface vga_mem_arbiter_if
  import vga_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;

  logic              host_req;
  logic [ADDR_W-1:0] host_addr;
  logic [3:0]        host_byteena;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic [ADDR_W-1:0] address_b;
  logic [3:0]        byteena_b;
  logic              rden_b;
  logic [DATA_W-1:0] q_b;

  modport slave (
    input  disp_req, disp_addr, host_req, host_addr, host_byteena, q_b,
    output disp_gnt, disp_rvalid, disp_rdata,
    output host_gnt, host_rvalid, host_rdata,
    output address_b, byteena_b, rden_b
  );

  modport master (
    output disp_req, disp_addr, host_req, host_addr, host_byteena, q_b,
    input  disp_gnt, disp_rvalid, disp_rdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  address_b, byteena_b, rden_b
  );
endinterface

// File: rtl/rd_tag_pipe.sv
// Read-tag delay line: tags an issued read with its requester until q_b returns.
// Latency RAM_LAT cycles, no backpressure (one tag shifts in every cycle).
module rd_tag_pipe
  import vga_mem_pkg::*;
#(
  parameter int RAM_LAT = 3
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage [RAM_LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RAM_LAT; i++) stage[i] <= TAG_NONE;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < RAM_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[RAM_LAT-1];

endmodule

// File: rtl/vga_mem_arbiter.sv
// Port-b read arbiter: display has fixed priority; VGA_ARB_STARVE_GUARD_EN adds a host starvation guard.
// Latency: rden_b one cycle after grant, *_rvalid/*_rdata RD_LAT+2 cycles after grant.
// Backpressure: requests hold until gnt; return path has none, rvalid must be taken when it pulses.
module vga_mem_arbiter
  import vga_mem_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 16
) (
  input logic              clk,
  input logic              reset,
  vga_mem_arbiter_if.slave bus
);

  if (RD_LAT < 1 || RD_LAT > 4 || MAX_WAIT < 2) begin : g_bad_param
    $error("vga_mem_arbiter: RD_LAT must be 1..4 and MAX_WAIT at least 2");
  end

  logic    force_host;
  logic    disp_gnt;
  logic    host_gnt;
  rd_tag_t tag_in;
  rd_tag_t tag_out;

  assign disp_gnt     = bus.disp_req & ~force_host;
  assign host_gnt     = bus.host_req & (~bus.disp_req | force_host);
  assign bus.disp_gnt = disp_gnt;
  assign bus.host_gnt = host_gnt;

  always_comb begin
    tag_in = TAG_NONE;
    if (disp_gnt)      tag_in = TAG_DISP;
    else if (host_gnt) tag_in = TAG_HOST;
  end

  // address_b/byteena_b keep their last value on idle cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rden_b    <= 1'b0;
      bus.address_b <= '0;
      bus.byteena_b <= 4'h0;
    end else begin
      bus.rden_b <= disp_gnt | host_gnt;
      if (disp_gnt) begin
        bus.address_b <= bus.disp_addr;
        bus.byteena_b <= 4'hF;
      end else if (host_gnt) begin
        bus.address_b <= bus.host_addr;
        bus.byteena_b <= bus.host_byteena;
      end
    end
  end

  // One extra stage past RD_LAT lines the tag up with q_b for the capture register.
  rd_tag_pipe #(.RAM_LAT(RD_LAT + 1)) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.disp_rvalid <= 1'b0;
      bus.host_rvalid <= 1'b0;
      bus.disp_rdata  <= '0;
      bus.host_rdata  <= '0;
    end else begin
      bus.disp_rvalid <= (tag_out == TAG_DISP);
      bus.host_rvalid <= (tag_out == TAG_HOST);
      if (tag_out == TAG_DISP) bus.disp_rdata <= bus.q_b;
      if (tag_out == TAG_HOST) bus.host_rdata <= bus.q_b;
    end
  end

`ifdef VGA_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(MAX_WAIT);

  arb_state_t       state;
  logic [CNT_W-1:0] wait_cnt;

  // Entering FORCE_HOST coincides with the counter stepping onto MAX_WAIT-1,
  // so the forced slot lands once every MAX_WAIT cycles under full contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_NORMAL;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_NORMAL: begin
          if (bus.host_req && !host_gnt) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == CNT_W'(MAX_WAIT - 2)) state <= ST_FORCE_HOST;
          end else begin
            wait_cnt <= '0;
          end
        end
        default: begin
          state    <= ST_NORMAL;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  assign force_host = (state == ST_FORCE_HOST);
`else
  assign force_host = 1'b0;
`endif

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: RAM model with RD_LAT read delay and an in-order return scoreboard.
module tb_vga_mem_arbiter;
  import vga_mem_pkg::*;

  localparam int ADDR_W   = 17;
  localparam int DATA_W   = 32;
  localparam int RD_LAT   = 2;
  localparam int MAX_WAIT = 16;

  typedef struct {
    rd_tag_t           tag;
    logic [DATA_W-1:0] data;
    int                gcyc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  vga_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vga_mem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RD_LAT   (RD_LAT),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
    if (a == 17'h00010) return 32'hDEADBEEF;
    return {a[14:0], a} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RAM port b: data for the address presented with rden_b appears RD_LAT cycles later
  logic [DATA_W-1:0] ram_pipe [RD_LAT];
  always @(posedge clk) begin
    ram_pipe[0] <= bus.rden_b ? ram_word(bus.address_b) : '0;
    for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign bus.q_b = ram_pipe[RD_LAT-1];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      check("gnt_excl", 64'(bus.disp_gnt & bus.host_gnt), 64'd0);
      if (bus.disp_rvalid || bus.host_rvalid) begin
        if (sb.size() == 0) begin
          check("spurious_rvalid", 64'({bus.disp_rvalid, bus.host_rvalid}), 64'd0);
        end else begin
          e = sb.pop_front();
          check("rvalid_route", 64'({bus.disp_rvalid, bus.host_rvalid}),
                (e.tag == TAG_DISP) ? 64'd2 : 64'd1);
          check("rdata", (e.tag == TAG_DISP) ? 64'(bus.disp_rdata) : 64'(bus.host_rdata),
                64'(e.data));
          check("rlat", 64'(cyc - e.gcyc), 64'(RD_LAT + 2));
        end
      end
      if (bus.disp_gnt) sb.push_back('{TAG_DISP, ram_word(bus.disp_addr), cyc});
      if (bus.host_gnt) sb.push_back('{TAG_HOST, ram_word(bus.host_addr), cyc});
    end
  end

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_rden_b"},      64'(bus.rden_b),      64'd0);
    check({pfx, "_address_b"},   64'(bus.address_b),   64'd0);
    check({pfx, "_byteena_b"},   64'(bus.byteena_b),   64'd0);
    check({pfx, "_disp_rvalid"}, 64'(bus.disp_rvalid), 64'd0);
    check({pfx, "_host_rvalid"}, 64'(bus.host_rvalid), 64'd0);
    check({pfx, "_disp_rdata"},  64'(bus.disp_rdata),  64'd0);
    check({pfx, "_host_rdata"},  64'(bus.host_rdata),  64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int rden_cnt, rv_cnt, rden_run, rv_run, rden_max, rv_max;
    int hg, dg, first_h, last_h, bad_gap;

    bus.disp_req     = 1'b0;
    bus.disp_addr    = '0;
    bus.host_req     = 1'b0;
    bus.host_addr    = '0;
    bus.host_byteena = 4'h0;

    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1 reset = 1'b0;

    // single display read
    @(posedge clk); #1 bus.disp_req = 1'b1; bus.disp_addr = 17'h00010;
    @(negedge clk);
    check("t1_disp_gnt", 64'(bus.disp_gnt), 64'd1);
    check("t1_host_gnt", 64'(bus.host_gnt), 64'd0);
    @(posedge clk); #1 bus.disp_req = 1'b0;
    @(negedge clk);
    check("t1_rden_b",    64'(bus.rden_b),    64'd1);
    check("t1_address_b", 64'(bus.address_b), 64'h00010);
    check("t1_byteena_b", 64'(bus.byteena_b), 64'hF);
    drain("t1_drain");
    check("t1_disp_rdata", 64'(bus.disp_rdata), 64'hDEADBEEF);

    // simultaneous requests: display first, host next
    @(posedge clk); #1
    bus.disp_req = 1'b1; bus.disp_addr = 17'h00020;
    bus.host_req = 1'b1; bus.host_addr = 17'h1FFFF; bus.host_byteena = 4'h3;
    @(negedge clk);
    check("t2_disp_gnt", 64'(bus.disp_gnt), 64'd1);
    check("t2_host_gnt", 64'(bus.host_gnt), 64'd0);
    @(posedge clk); #1 bus.disp_req = 1'b0;
    @(negedge clk);
    check("t2_host_gnt2", 64'(bus.host_gnt), 64'd1);
    check("t2_disp_gnt2", 64'(bus.disp_gnt), 64'd0);
    @(posedge clk); #1 bus.host_req = 1'b0;
    @(negedge clk);
    check("t2_rden_b",    64'(bus.rden_b),    64'd1);
    check("t2_address_b", 64'(bus.address_b), 64'h1FFFF);
    check("t2_byteena_b", 64'(bus.byteena_b), 64'h3);
    drain("t2_drain");
    check("t2_host_rdata", 64'(bus.host_rdata), 64'(ram_word(17'h1FFFF)));

    // 8-deep display burst at full rate
    rden_cnt = 0; rv_cnt = 0; rden_run = 0; rv_run = 0; rden_max = 0; rv_max = 0;
    for (int i = 0; i < 8 + RD_LAT + 6; i++) begin
      @(posedge clk); #1
      bus.disp_req  = (i < 8);
      bus.disp_addr = ADDR_W'(i < 8 ? i : 0);
      @(negedge clk);
      rden_cnt += int'(bus.rden_b);
      rv_cnt   += int'(bus.disp_rvalid);
      rden_run  = bus.rden_b ? rden_run + 1 : 0;
      rv_run    = bus.disp_rvalid ? rv_run + 1 : 0;
      if (rden_run > rden_max) rden_max = rden_run;
      if (rv_run > rv_max) rv_max = rv_run;
    end
    check("t3_rden_cnt", 64'(rden_cnt), 64'd8);
    check("t3_rden_run", 64'(rden_max), 64'd8);
    check("t3_rv_cnt",   64'(rv_cnt),   64'd8);
    check("t3_rv_run",   64'(rv_max),   64'd8);
    drain("t3_drain");

    // full contention for 100 cycles
    hg = 0; dg = 0; first_h = -1; last_h = -1; bad_gap = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1
      bus.disp_req = 1'b1; bus.disp_addr = ADDR_W'(17'h00200 + i);
      bus.host_req = 1'b1; bus.host_addr = 17'h00100; bus.host_byteena = 4'hC;
      @(negedge clk);
      if (bus.disp_gnt) dg++;
      if (bus.host_gnt) begin
        hg++;
        if (first_h < 0) first_h = i;
        if (last_h >= 0 && (i - last_h) != MAX_WAIT) bad_gap++;
        last_h = i;
      end
    end
    @(posedge clk); #1 bus.disp_req = 1'b0; bus.host_req = 1'b0;
`ifdef VGA_ARB_STARVE_GUARD_EN
    check("t4_host_gnts",  64'(hg),      64'(100 / MAX_WAIT));
    check("t4_first_host", 64'(first_h), 64'(MAX_WAIT - 1));
    check("t4_host_gap",   64'(bad_gap), 64'd0);
    check("t4_disp_gnts",  64'(dg),      64'(100 - 100 / MAX_WAIT));
`else
    check("t4_host_gnts", 64'(hg), 64'd0);
    check("t4_disp_gnts", 64'(dg), 64'd100);
`endif
    drain("t4_drain");

    // asynchronous reset with two reads in flight
    @(posedge clk); #1 bus.disp_req = 1'b1; bus.disp_addr = 17'h00030;
    @(posedge clk); #1 bus.disp_addr = 17'h00031;
    @(posedge clk); #1 bus.disp_req = 1'b0;
    #2 reset = 1'b1;
    sb.delete();
    #1 check_reset_vals("t5");
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_no_rvalid", 64'({bus.disp_rvalid, bus.host_rvalid}), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
